debug_run_controller: RTL



---
 rtl/debug_pkg.sv | 37 +++
 rtl/dbg_cycle_timer.sv | 35 +++
 rtl/debug_run_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the serial-debugger run controller: FSM states,
// command bytes and where cycle_count sits inside the transmitted snapshot.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_STEP      = 3'd2,
    ST_RUN       = 3'd3,
    ST_RST       = 3'd4,
    ST_SEND      = 3'd5,
    ST_WAIT_SENT = 3'd6
  } dbg_state_e;

  localparam logic [7:0]  CMD_STEP  = 8'h73;
  localparam logic [7:0]  CMD_CONT  = 8'h63;
  localparam logic [7:0]  CMD_BREAK = 8'h62;
  localparam logic [7:0]  CMD_RESET = 8'h72;

  localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

  // cycle_count travels little-endian starting at this snapshot byte
  localparam int unsigned SNAP_CYCLE_OFFSET = 0;
  localparam int unsigned SNAP_CYCLE_BYTES  = 4;

  function automatic logic [7:0] snap_cycle_byte(input logic [31:0] count,
                                                 input int unsigned pos);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < SNAP_CYCLE_BYTES; i++) begin
      if (pos == SNAP_CYCLE_OFFSET + i) b = count[8*i +: 8];
      else                              b = b;
    end
    return b;
  endfunction

endpackage

// File: rtl/dbg_cycle_timer.sv
// Loadable down-counter; done_o flags the final cycle of the loaded period
// (count of 1, or an empty/zero load).
module dbg_cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = W'(0);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over decrement, stop at zero
  always_comb begin
    count_d = count_q;
    if (load_i)                       count_d = load_val_i;
    else if (en_i && count_q != ZERO) count_d = count_q - ONE;
    else                              count_d = count_q;
  end

  // Counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= ZERO;
    else       count_q <= count_d;
  end

  assign done_o = (count_q <= ONE);

endmodule

// File: rtl/debug_run_controller.sv
// Sequences UART debug commands into CPU step/run/reset and snapshot requests.
// Defining DEBUG_RUN_WATCHDOG_EN adds a RUN-length watchdog (wdt_expired).
module debug_run_controller
  import debug_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned WDT_CYCLES  = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  input  logic        cpu_halted,
  output logic        cpu_enable,
  output logic        cpu_reset,
  output logic        sendSignal,
  input  logic        dataSent,
  output logic        busy,
  output logic [31:0] cycle_count,
  output logic        wdt_expired
);

  localparam logic [31:0] STEP_LOAD = 32'(STEP_CYCLES);
  localparam logic [31:0] RST_LOAD  = 32'(RST_CYCLES);
  localparam logic [31:0] WDT_LOAD  = 32'(WDT_CYCLES);

  dbg_state_e  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] cycle_q, cycle_d;
  logic        rd_uart_q, rd_uart_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        send_q, send_d;
  logic        busy_q, busy_d;
  logic        wdt_q, wdt_d;

  logic        tmr_load, tmr_en, tmr_done, wdt_hit, break_seen;
  logic [31:0] tmr_val;

  dbg_cycle_timer #(.W(32)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

`ifdef DEBUG_RUN_WATCHDOG_EN
  assign wdt_hit = tmr_done;
  assign tmr_en  = (state_q == ST_STEP) || (state_q == ST_RST) || (state_q == ST_RUN);
`else
  assign wdt_hit = 1'b0;
  assign tmr_en  = (state_q == ST_STEP) || (state_q == ST_RST);
`endif

  assign break_seen = rx_ready && (r_data == CMD_BREAK);

  // Next-state, timer control and next values of every registered output
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rd_uart_d = 1'b0;
    wdt_d     = wdt_q;
    tmr_load  = 1'b0;
    tmr_val   = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          cmd_d     = r_data;
          rd_uart_d = 1'b1;
          state_d   = ST_DECODE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_DECODE: begin
        wdt_d = 1'b0;
        case (cmd_q)
          CMD_STEP: begin
            if (cpu_halted) begin
              state_d  = ST_SEND;
            end else begin
              state_d  = ST_STEP;
              tmr_load = 1'b1;
              tmr_val  = STEP_LOAD;
            end
          end
          CMD_CONT: begin
            if (cpu_halted) begin
              state_d  = ST_SEND;
            end else begin
              state_d  = ST_RUN;
              tmr_load = 1'b1;
              tmr_val  = WDT_LOAD;
            end
          end
          CMD_RESET: begin
            state_d  = ST_RST;
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_STEP: begin
        if (tmr_done || cpu_halted) state_d = ST_SEND;
        else                        state_d = ST_STEP;
      end
      // Break takes priority so its byte is always popped, even alongside a halt
      ST_RUN: begin
        if (break_seen) begin
          state_d   = ST_SEND;
          rd_uart_d = 1'b1;
        end else if (cpu_halted) begin
          state_d   = ST_SEND;
        end else if (wdt_hit) begin
          state_d   = ST_SEND;
          wdt_d     = 1'b1;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_RST: begin
        if (tmr_done) state_d = ST_SEND;
        else          state_d = ST_RST;
      end
      ST_SEND: state_d = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (dataSent) state_d = ST_IDLE;
        else          state_d = ST_WAIT_SENT;
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_enable_d = (state_d == ST_STEP) || (state_d == ST_RUN);
    cpu_reset_d  = (state_d == ST_RST);
    send_d       = (state_d == ST_SEND);
    busy_d       = (state_d != ST_IDLE);

    if (state_q == ST_DECODE && state_d == ST_RST)  cycle_d = 32'd0;
    else if (cpu_enable_q && cycle_q != CYCLE_MAX)  cycle_d = cycle_q + 32'd1;
    else                                            cycle_d = cycle_q;
  end

  // State, command latch, counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      cycle_q      <= 32'd0;
      rd_uart_q    <= 1'b0;
      cpu_enable_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
      wdt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cycle_q      <= cycle_d;
      rd_uart_q    <= rd_uart_d;
      cpu_enable_q <= cpu_enable_d;
      cpu_reset_q  <= cpu_reset_d;
      send_q       <= send_d;
      busy_q       <= busy_d;
      wdt_q        <= wdt_d;
    end
  end

  assign rd_uart     = rd_uart_q;
  assign cpu_enable  = cpu_enable_q;
  assign cpu_reset   = cpu_reset_q;
  assign sendSignal  = send_q;
  assign busy        = busy_q;
  assign cycle_count = cycle_q;
  assign wdt_expired = wdt_q;

endmodule
